// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles everything that passes between the hazard/stall controller and the
// five-stage datapath, so the two sides share one port.
//
// Signal summary
//   Datapath -> controller (hazard status)
//     ihit, dhit                  : fetch / data access completed this cycle
//     exmem_dREN, exmem_dWEN      : memory op sitting in MEM
//     exmem_branch, exmem_jump    : control transfer resolved in MEM
//     exmem_halt                  : halt instruction in MEM
//     idex_dREN, idex_rd          : load in EX and its destination register
//     ifid_rs1, ifid_rs2          : source registers of the instruction in ID
//   Controller -> datapath (pipeline control)
//     pc_en                       : PC update enable
//     ifid/idex/exmem/memwb _en   : pipeline latch enables
//     ifid/idex/exmem/memwb _flush: latch flush (bubble insert)
//     halt_o, state_o             : sticky halt flag, controller state
//     stall_cnt, redir_cnt        : saturating performance counters
//
// Modports
//   master : the controller (consumes status, drives control)
//   slave  : the datapath   (drives status, consumes control)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;

   // hazard status from the datapath
   logic        ihit;
   logic        dhit;
   logic        exmem_dREN;
   logic        exmem_dWEN;
   logic        exmem_branch;
   logic        exmem_jump;
   logic        exmem_halt;
   logic        idex_dREN;
   logic [4:0]  idex_rd;
   logic [4:0]  ifid_rs1;
   logic [4:0]  ifid_rs2;

   // pipeline control back to the datapath
   logic        pc_en;
   logic        ifid_en;
   logic        idex_en;
   logic        exmem_en;
   logic        memwb_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        exmem_flush;
   logic        memwb_flush;
   logic        halt_o;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt;
   logic [15:0] redir_cnt;

   modport master (
      input  ihit, dhit,
      input  exmem_dREN, exmem_dWEN, exmem_branch, exmem_jump, exmem_halt,
      input  idex_dREN, idex_rd, ifid_rs1, ifid_rs2,
      output pc_en,
      output ifid_en, idex_en, exmem_en, memwb_en,
      output ifid_flush, idex_flush, exmem_flush, memwb_flush,
      output halt_o, state_o, stall_cnt, redir_cnt
   );

   modport slave (
      output ihit, dhit,
      output exmem_dREN, exmem_dWEN, exmem_branch, exmem_jump, exmem_halt,
      output idex_dREN, idex_rd, ifid_rs1, ifid_rs2,
      input  pc_en,
      input  ifid_en, idex_en, exmem_en, memwb_en,
      input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
      input  halt_o, state_o, stall_cnt, redir_cnt
   );

endinterface

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and stall controller for a five-stage pipeline. Every control output
// is a combinational function of the current state and the current hazard
// inputs (no added latency); only the FSM state and the two performance
// counters are registered.
//
// Ports
//   CLK  : clock
//   nRST : asynchronous, active-low reset
//   bus  : pipeline_ctrl_if.master -- hazard status in, latch control out
//
// Condition priority (highest first):
//   HALTED, data stall, halt, redirect, load-use, fetch miss, normal
//
// Latch vectors below are ordered {ifid, idex, exmem, memwb}.
// -----------------------------------------------------------------------------
module pipeline_ctrl (
   input  logic            CLK,
   input  logic            nRST,
   pipeline_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

   // Latch enable / flush patterns, {ifid, idex, exmem, memwb}
   localparam logic [3:0] LAT_NONE  = 4'b0000;
   localparam logic [3:0] LAT_ALL   = 4'b1111;
   localparam logic [3:0] LAT_MEMWB = 4'b0001;
   localparam logic [3:0] LAT_FRONT = 4'b1110;  // ifid, idex, exmem
   localparam logic [3:0] LAT_BACK  = 4'b0111;  // idex, exmem, memwb
   localparam logic [3:0] LAT_IDEX  = 4'b0100;
   localparam logic [3:0] LAT_IFID  = 4'b1000;

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   state_t      state_q, state_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] redir_cnt_q, redir_cnt_d;

   // ------------------------------------------------------------------
   // Hazard decode
   // ------------------------------------------------------------------
   logic dmem_pend;
   logic data_stall;
   logic load_use;
   logic redirect;
   logic rd_nonzero;
   logic rd_match;

   assign dmem_pend  = bus.exmem_dREN | bus.exmem_dWEN;
   assign data_stall = dmem_pend & ~bus.dhit;
   assign redirect   = bus.exmem_branch | bus.exmem_jump;
   assign rd_nonzero = (bus.idex_rd != 5'd0);
   assign rd_match   = (bus.idex_rd == bus.ifid_rs1) |
                       (bus.idex_rd == bus.ifid_rs2);
   // x0 is hard-wired zero, so a load targeting it can never create a hazard
   assign load_use   = bus.idex_dREN & rd_nonzero & rd_match;

   // ------------------------------------------------------------------
   // Raw (pre-reset-gating) control decisions
   // ------------------------------------------------------------------
   logic       pc_en_c;
   logic [3:0] en_c;
   logic [3:0] flush_c;
   logic       halt_c;
   logic       redir_take;

   // Next-state and control decode. Any state encoding other than DWAIT or
   // HALTED (including the unused 2'd3) takes the RUN path.
   always_comb begin
      pc_en_c    = 1'b0;
      en_c       = LAT_NONE;
      flush_c    = LAT_NONE;
      halt_c     = 1'b0;
      redir_take = 1'b0;
      state_d    = state_q;

      if (state_q == HALTED) begin
         // Frozen until reset; everything stays disabled.
         halt_c  = 1'b1;
         state_d = HALTED;
      end else begin
         // RUN and DWAIT share one decode: DWAIT only differs in that it is
         // entered by a data stall, and it is left as soon as the stall ends
         // (dhit arrives, or the memory op disappears).
         state_d = RUN;
         if (data_stall) begin
            // Hold everything upstream of MEM; drain WB with a bubble so the
            // stalled MEM instruction is not written back twice.
            en_c    = LAT_MEMWB;
            flush_c = LAT_MEMWB;
            state_d = DWAIT;
         end else if (bus.exmem_halt) begin
            // Let the halt retire into WB while squashing everything younger.
            en_c    = LAT_ALL;
            flush_c = LAT_FRONT;
            state_d = HALTED;
         end else if (redirect) begin
            // Younger instructions are on the wrong path; the PC takes the
            // new target this cycle, so load-use and fetch miss are moot.
            pc_en_c    = 1'b1;
            en_c       = LAT_ALL;
            flush_c    = LAT_FRONT;
            redir_take = 1'b1;
         end else if (load_use) begin
            // Keep the consumer in ID for one cycle, bubble into EX.
            en_c    = LAT_BACK;
            flush_c = LAT_IDEX;
         end else if (!bus.ihit) begin
            // Fetch not ready: hold PC, push a bubble into ID.
            en_c    = LAT_ALL;
            flush_c = LAT_IFID;
         end else begin
            pc_en_c = 1'b1;
            en_c    = LAT_ALL;
         end
      end
   end

   // ------------------------------------------------------------------
   // Performance counters (saturating)
   // ------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;

      // A halted core is not "stalled"; only count frozen-PC cycles while
      // the pipeline is live.
      if (!pc_en_c && (state_q != HALTED) && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if (redir_take && (redir_cnt_q != CNT_MAX)) begin
         redir_cnt_d = redir_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         stall_cnt_q <= 16'd0;
         redir_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. Control is combinational, so it is gated with nRST to keep
   // every latch idle while reset is held, independent of the inputs.
   // ------------------------------------------------------------------
   assign bus.pc_en       = nRST & pc_en_c;
   assign bus.ifid_en     = nRST & en_c[3];
   assign bus.idex_en     = nRST & en_c[2];
   assign bus.exmem_en    = nRST & en_c[1];
   assign bus.memwb_en    = nRST & en_c[0];
   assign bus.ifid_flush  = nRST & flush_c[3];
   assign bus.idex_flush  = nRST & flush_c[2];
   assign bus.exmem_flush = nRST & flush_c[1];
   assign bus.memwb_flush = nRST & flush_c[0];
   assign bus.halt_o      = nRST & halt_c;
   assign bus.state_o     = state_q;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.redir_cnt   = redir_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl. Each test task builds a short table
// of cycles (stimulus + expected control pattern); expected observations are
// pushed to a scoreboard queue when the stimulus is driven and popped and
// compared once the outputs have settled in that cycle.
//
// Timing: inputs change on the falling edge, outputs are sampled 2 time units
// later, the rising edge follows 3 units after that.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

   logic CLK;
   logic nRST;

   pipeline_ctrl_if bus ();

   pipeline_ctrl dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_DWAIT  = 2'd1;
   localparam logic [1:0] ST_HALTED = 2'd2;

   // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
   //  ifid_flush, idex_flush, exmem_flush, memwb_flush}
   localparam logic [8:0] C_OFF    = 9'b0_0000_0000;
   localparam logic [8:0] C_NORMAL = 9'b1_1111_0000;
   localparam logic [8:0] C_DSTALL = 9'b0_0001_0001;
   localparam logic [8:0] C_HALT   = 9'b0_1111_1110;
   localparam logic [8:0] C_REDIR  = 9'b1_1111_1110;
   localparam logic [8:0] C_LU     = 9'b0_0111_0100;
   localparam logic [8:0] C_FMISS  = 9'b0_1111_1000;

   typedef struct packed {
      logic       ihit;
      logic       dhit;
      logic       dren;
      logic       dwen;
      logic       br;
      logic       jmp;
      logic       hlt;
      logic       idren;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } stim_t;

   typedef struct packed {
      logic [8:0]  ctl;
      logic        halt;
      logic [1:0]  st;
      logic [15:0] stall;
      logic [15:0] redir;
   } obs_t;

   typedef struct packed {
      logic       rst;
      stim_t      s;
      logic [8:0] ctl;
      logic       h;
      logic [1:0] st;
   } row_t;

   obs_t        exp_q[$];
   logic [15:0] m_stall;
   logic [15:0] m_redir;
   int          n_checks;
   int          n_fail;

   function automatic stim_t S(input logic ihit, input logic dhit,
                               input logic dren, input logic dwen,
                               input logic br, input logic jmp,
                               input logic hlt, input logic idren,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2);
      stim_t s;
      s.ihit = ihit; s.dhit = dhit; s.dren = dren; s.dwen = dwen;
      s.br = br; s.jmp = jmp; s.hlt = hlt; s.idren = idren;
      s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
      return s;
   endfunction

   function automatic row_t mk(input logic rst, input stim_t s,
                               input logic [8:0] ctl, input logic h,
                               input logic [1:0] st);
      row_t r;
      r.rst = rst; r.s = s; r.ctl = ctl; r.h = h; r.st = st;
      return r;
   endfunction

   // Plain stimulus shorthands
   function automatic stim_t s_norm();
      return S(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
   endfunction

   // Drive one cycle of stimulus and push what the outputs must show in it.
   // Counters observed this cycle reflect earlier edges; the model then
   // advances them for the edge that closes this cycle.
   task automatic apply(input row_t r);
      obs_t e;
      nRST             = ~r.rst;
      bus.ihit         = r.s.ihit;
      bus.dhit         = r.s.dhit;
      bus.exmem_dREN   = r.s.dren;
      bus.exmem_dWEN   = r.s.dwen;
      bus.exmem_branch = r.s.br;
      bus.exmem_jump   = r.s.jmp;
      bus.exmem_halt   = r.s.hlt;
      bus.idex_dREN    = r.s.idren;
      bus.idex_rd      = r.s.rd;
      bus.ifid_rs1     = r.s.rs1;
      bus.ifid_rs2     = r.s.rs2;
      if (r.rst) begin
         m_stall = 16'd0;
         m_redir = 16'd0;
      end
      e.ctl   = r.ctl;
      e.halt  = r.h;
      e.st    = r.st;
      e.stall = m_stall;
      e.redir = m_redir;
      exp_q.push_back(e);
      if (!r.rst) begin
         if (!r.ctl[8] && (r.st != ST_HALTED) && (m_stall != 16'hFFFF))
            m_stall = m_stall + 16'd1;
         if ((r.ctl == C_REDIR) && (m_redir != 16'hFFFF))
            m_redir = m_redir + 16'd1;
      end
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.ctl   = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en,
                 bus.memwb_en, bus.ifid_flush, bus.idex_flush,
                 bus.exmem_flush, bus.memwb_flush};
      o.halt  = bus.halt_o;
      o.st    = bus.state_o;
      o.stall = bus.stall_cnt;
      o.redir = bus.redir_cnt;
      return o;
   endfunction

   // ------------------------------------------------------------------
   task automatic test_reset();
      row_t rows[$];
      obs_t got, want;
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      rows.push_back(mk(1, S(0, 0, 1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0), C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   reset[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_data_stall();
      row_t rows[$];
      obs_t got, want;
      stim_t miss, hit;
      miss = S(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      hit  = S(1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_RUN));
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));
      rows.push_back(mk(0, hit,  C_NORMAL, 0, ST_DWAIT));   // stall_cnt = 3
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN)); // stall_cnt = 3
      // DWAIT left because the memory op vanished
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), C_NORMAL, 0, ST_DWAIT));
      // hit in RUN: no stall at all
      rows.push_back(mk(0, hit, C_NORMAL, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL data_stall[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   data_stall[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_load_use();
      row_t rows[$];
      obs_t got, want;
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5), C_LU, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0), C_NORMAL, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2), C_LU, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5), C_NORMAL, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd8, 5'd10), C_NORMAL, 0, ST_RUN));
      // load-use outranks a fetch miss
      rows.push_back(mk(0, S(0, 0, 0, 0, 0, 0, 0, 1, 5'd31, 5'd31, 5'd1), C_LU, 0, ST_RUN));
      rows.push_back(mk(0, S(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), C_FMISS, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL load_use[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   load_use[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_redirect();
      row_t rows[$];
      obs_t got, want;
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      // branch + load-use + fetch miss together
      rows.push_back(mk(0, S(0, 0, 0, 0, 1, 0, 0, 1, 5'd4, 5'd4, 5'd0), C_REDIR, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));   // redir_cnt = 1
      rows.push_back(mk(0, S(1, 0, 0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0), C_REDIR, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));   // redir_cnt = 2
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL redirect[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   redirect[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_deferred_redirect();
      row_t rows[$];
      obs_t got, want;
      stim_t miss_j, hit_j;
      miss_j = S(1, 0, 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      hit_j  = S(1, 1, 0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, miss_j, C_DSTALL, 0, ST_RUN));
      rows.push_back(mk(0, miss_j, C_DSTALL, 0, ST_DWAIT));
      rows.push_back(mk(0, hit_j,  C_REDIR,  0, ST_DWAIT));   // redir_cnt still 0
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));   // redir_cnt = 1
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL deferred_redirect[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   deferred_redirect[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_halt();
      row_t rows[$];
      obs_t got, want;
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, S(1, 0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0), C_REDIR, 0, ST_RUN));
      // halt outranks the redirect alongside it
      rows.push_back(mk(0, S(1, 0, 0, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0), C_HALT, 0, ST_RUN));
      for (int k = 0; k < 10; k++) begin
         rows.push_back(mk(0, S(k[0], 1, 0, 0, k[1], 0, 1, 0, 5'd0, 5'd0, 5'd0), C_OFF, 1, ST_HALTED));
      end
      rows.push_back(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL halt[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   halt[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid_dwait();
      row_t rows[$];
      obs_t got, want;
      stim_t miss;
      miss = S(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_RUN));
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));
      rows.push_back(mk(1, miss, C_OFF, 0, ST_RUN));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid_dwait[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   reset_mid_dwait[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   task automatic test_stall_saturation();
      row_t rows[$];
      obs_t got, want;
      stim_t miss;
      miss = S(1, 0, 1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      // Reset, then hold a data miss until the counter reaches 16'hFFFE.
      @(negedge CLK);
      apply(mk(1, s_norm(), C_OFF, 0, ST_RUN));
      void'(exp_q.pop_front());
      @(negedge CLK);
      apply(mk(0, miss, C_DSTALL, 0, ST_RUN));
      void'(exp_q.pop_front());
      repeat (65533) @(negedge CLK);
      m_stall = 16'hFFFE;
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));  // FFFE
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));  // FFFF
      rows.push_back(mk(0, miss, C_DSTALL, 0, ST_DWAIT));  // FFFF held
      rows.push_back(mk(0, S(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0), C_FMISS, 0, ST_DWAIT));
      rows.push_back(mk(0, s_norm(), C_NORMAL, 0, ST_RUN));
      foreach (rows[i]) begin
         @(negedge CLK);
         apply(rows[i]);
         #2;
         got  = sample();
         want = exp_q.pop_front();
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL stall_saturation[%0d] got ctl=%b halt=%b st=%0d stall=%h redir=%h, want ctl=%b halt=%b st=%0d stall=%h redir=%h",
                     i, got.ctl, got.halt, got.st, got.stall, got.redir,
                     want.ctl, want.halt, want.st, want.stall, want.redir);
         end else
            $display("ok   stall_saturation[%0d] ctl=%b st=%0d stall=%h redir=%h", i, got.ctl, got.st, got.stall, got.redir);
      end
   endtask

   // ------------------------------------------------------------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      m_stall  = 16'd0;
      m_redir  = 16'd0;
      nRST             = 1'b0;
      bus.ihit         = 1'b0;
      bus.dhit         = 1'b0;
      bus.exmem_dREN   = 1'b0;
      bus.exmem_dWEN   = 1'b0;
      bus.exmem_branch = 1'b0;
      bus.exmem_jump   = 1'b0;
      bus.exmem_halt   = 1'b0;
      bus.idex_dREN    = 1'b0;
      bus.idex_rd      = 5'd0;
      bus.ifid_rs1     = 5'd0;
      bus.ifid_rs2     = 5'd0;

      test_reset();
      test_data_stall();
      test_load_use();
      test_redirect();
      test_deferred_redirect();
      test_halt();
      test_reset_mid_dwait();
      test_stall_saturation();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
